// File: rtl/sa_rdata_responder_pkg.sv
// Shared definitions for the AXI4 read-data responder: burst/response encodings,
// FSM states and the width of a queued AR request.
package sa_rdata_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  // Queued AR entry is {ID, ADDR, LEN(8), SIZE(3), BURST(2)}
  function automatic int ar_info_w(input int id_w, input int addr_w);
    return id_w + addr_w + 8 + 3 + 2;
  endfunction

endpackage

// File: rtl/sa_rdata_responder_addr_gen.sv
// Combinational next-beat address and burst legality check for one AXI read burst.
module sa_rdata_responder_addr_gen
  import sa_rdata_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  slv_err
);

  localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] size_bytes;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  logic                  wrap_len_ok;

  always_comb begin
    size_bytes  = ADDR_WIDTH'(1) << size;
    wrap_bytes  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    incr_addr   = (addr & ~(size_bytes - ADDR_WIDTH'(1))) + size_bytes;
    wrap_addr   = (addr & ~(wrap_bytes - ADDR_WIDTH'(1))) |
                  ((addr + size_bytes) & (wrap_bytes - ADDR_WIDTH'(1)));
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    slv_err     = (burst == BURST_RSVD) ||
                  (size > 3'(LANE_BITS)) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);

    // Illegal bursts still walk memory, using plain incrementing addresses
    if (slv_err) begin
      next_addr = incr_addr;
    end else begin
      case (burst_e'(burst))
        BURST_FIXED: next_addr = addr;
        BURST_WRAP:  next_addr = wrap_addr;
        default:     next_addr = incr_addr;
      endcase
    end
  end

endmodule

// File: rtl/sa_rdata_responder_fifo.sv
// Show-ahead synchronous FIFO used to queue accepted read-address requests.
module sa_rdata_responder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_reg];

  // Storage carries no reset so it can map onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (rd_en) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (wr_en && !rd_en) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!wr_en && rd_en) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sa_rdata_responder.sv
// Memory-backed AXI4 read slave: queues AR requests, walks each burst through a
// one-cycle-latency memory read port and returns R beats through a 2-entry buffer.
module sa_rdata_responder
  import sa_rdata_responder_pkg::*;
#(
  parameter int OUTSTANDING_AMT = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int TRANS_SLV_ID_W  = 7,
  parameter int TRANS_WR_RESP_W = 2
) (
  input  logic                       ACLK_i,
  input  logic                       ARESETn_i,
  input  logic [TRANS_SLV_ID_W-1:0]  m_ARID_i,
  input  logic [ADDR_WIDTH-1:0]      m_ARADDR_i,
  input  logic [7:0]                 m_ARLEN_i,
  input  logic [2:0]                 m_ARSIZE_i,
  input  logic [1:0]                 m_ARBURST_i,
  input  logic                       m_ARVALID_i,
  output logic                       m_ARREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]  m_RID_o,
  output logic [DATA_WIDTH-1:0]      m_RDATA_o,
  output logic [TRANS_WR_RESP_W-1:0] m_RRESP_o,
  output logic                       m_RLAST_o,
  output logic                       m_RVALID_o,
  input  logic                       m_RREADY_i,
  output logic                       mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);

  localparam int AR_INFO_W  = ar_info_w(TRANS_SLV_ID_W, ADDR_WIDTH);
  localparam int BYTE_LANES = DATA_WIDTH / 8;
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_OK_W  = TRANS_WR_RESP_W'(RESP_OKAY);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_ERR_W = TRANS_WR_RESP_W'(RESP_SLVERR);

  // ---------------- AR queue ----------------
  logic                      init_done_reg;
  logic                      ar_push;
  logic                      ar_pop;
  logic                      ar_full;
  logic                      ar_empty;
  logic [AR_INFO_W-1:0]      ar_push_info;
  logic [AR_INFO_W-1:0]      ar_head;
  logic [TRANS_SLV_ID_W-1:0] head_id;
  logic [ADDR_WIDTH-1:0]     head_addr;
  logic [7:0]                head_len;
  logic [2:0]                head_size;
  logic [1:0]                head_burst;

  // ARREADY stays low until the first clock after reset release
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
    end
  end

  assign m_ARREADY_o  = init_done_reg & ~ar_full;
  assign ar_push      = m_ARVALID_i & m_ARREADY_o;
  assign ar_push_info = {m_ARID_i, m_ARADDR_i, m_ARLEN_i, m_ARSIZE_i, m_ARBURST_i};
  assign {head_id, head_addr, head_len, head_size, head_burst} = ar_head;

  sa_rdata_responder_fifo #(
    .WIDTH (AR_INFO_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_ar_fifo (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .push      (ar_push),
    .push_data (ar_push_info),
    .pop       (ar_pop),
    .pop_data  (ar_head),
    .full      (ar_full),
    .empty     (ar_empty)
  );

  // ---------------- burst walker ----------------
  rd_state_e                 state_reg;
  rd_state_e                 state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [7:0]                len_reg;
  logic [2:0]                size_reg;
  logic [1:0]                burst_reg;
  logic [TRANS_SLV_ID_W-1:0] id_reg;
  logic [8:0]                beats_reg;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic                      burst_err;
  logic                      issue;
  logic                      credit_ok;
  logic                      r_pop;
  logic [2:0]                credit_used;

  sa_rdata_responder_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .addr      (addr_reg),
    .len       (len_reg),
    .size      (size_reg),
    .burst     (burst_reg),
    .next_addr (next_addr),
    .slv_err   (burst_err)
  );

  // ---------------- side pipe and output buffer state ----------------
  logic                      rd_pend_reg;
  logic [TRANS_SLV_ID_W-1:0] pend_id_reg;
  logic [TRANS_WR_RESP_W-1:0] pend_resp_reg;
  logic                      pend_last_reg;
  logic [1:0]                occ_reg;
  logic                      wr_sel_reg;
  logic                      rd_sel_reg;

  assign r_pop       = m_RVALID_o & m_RREADY_i;
  // Buffered beats plus the read in flight must leave room for one more
  assign credit_used = {1'b0, occ_reg} + {2'b00, rd_pend_reg} - {2'b00, r_pop};
  assign credit_ok   = (credit_used < 3'd2);

  always_comb begin
    state_next = state_reg;
    ar_pop     = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!ar_empty) begin
          ar_pop     = 1'b1;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (beats_reg == 9'd1) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      id_reg    <= '0;
      beats_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ar_pop) begin
        addr_reg  <= head_addr;
        len_reg   <= head_len;
        size_reg  <= head_size;
        burst_reg <= head_burst;
        id_reg    <= head_id;
        beats_reg <= {1'b0, head_len} + 9'd1;
      end else if (issue) begin
        addr_reg  <= next_addr;
        beats_reg <= beats_reg - 9'd1;
      end
    end
  end

  assign mem_rd_en_o = issue;
  assign mem_addr_o  = addr_reg & ~ADDR_WIDTH'(BYTE_LANES - 1);

  // ID/RRESP/LAST follow the read so they line up with mem_rdata_i
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      rd_pend_reg   <= 1'b0;
      pend_id_reg   <= '0;
      pend_resp_reg <= '0;
      pend_last_reg <= 1'b0;
    end else begin
      rd_pend_reg   <= issue;
      pend_id_reg   <= id_reg;
      pend_resp_reg <= burst_err ? RESP_ERR_W : RESP_OK_W;
      pend_last_reg <= (beats_reg == 9'd1);
    end
  end

  // ---------------- 2-entry R buffer ----------------
  logic [TRANS_SLV_ID_W-1:0]  slot_id   [2];
  logic [DATA_WIDTH-1:0]      slot_data [2];
  logic [TRANS_WR_RESP_W-1:0] slot_resp [2];
  logic                       slot_last [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [TRANS_SLV_ID_W-1:0]  id_reg_s;
      logic [DATA_WIDTH-1:0]      data_reg_s;
      logic [TRANS_WR_RESP_W-1:0] resp_reg_s;
      logic                       last_reg_s;

      always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
          id_reg_s   <= '0;
          data_reg_s <= '0;
          resp_reg_s <= '0;
          last_reg_s <= 1'b0;
        end else if (rd_pend_reg && (wr_sel_reg == 1'(gi))) begin
          id_reg_s   <= pend_id_reg;
          data_reg_s <= mem_rdata_i;
          resp_reg_s <= pend_resp_reg;
          last_reg_s <= pend_last_reg;
        end
      end

      assign slot_id[gi]   = id_reg_s;
      assign slot_data[gi] = data_reg_s;
      assign slot_resp[gi] = resp_reg_s;
      assign slot_last[gi] = last_reg_s;
    end
  endgenerate

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      occ_reg    <= 2'd0;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      if (rd_pend_reg) begin
        wr_sel_reg <= ~wr_sel_reg;
      end
      if (r_pop) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
      case ({rd_pend_reg, r_pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign m_RVALID_o = (occ_reg != 2'd0);
  assign m_RID_o    = slot_id[rd_sel_reg];
  assign m_RDATA_o  = slot_data[rd_sel_reg];
  assign m_RRESP_o  = slot_resp[rd_sel_reg];
  assign m_RLAST_o  = m_RVALID_o & slot_last[rd_sel_reg];

endmodule

// File: tb/tb_sa_rdata_responder.sv
// Scoreboard bench for sa_rdata_responder: expected memory addresses and R beats are
// queued at each AR handshake and compared as the DUT issues reads and returns beats.
`timescale 1ns/1ps
module tb_sa_rdata_responder;

  localparam int ID_W = 7;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ID_W-1:0] arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = '0;
  logic [1:0]      arburst = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [DW-1:0]   rdata;
  logic [RW-1:0]   rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b1;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  sa_rdata_responder #(
    .OUTSTANDING_AMT (8),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .TRANS_SLV_ID_W  (ID_W),
    .TRANS_WR_RESP_W (RW)
  ) dut (
    .ACLK_i      (clk),
    .ARESETn_i   (rst_n),
    .m_ARID_i    (arid),
    .m_ARADDR_i  (araddr),
    .m_ARLEN_i   (arlen),
    .m_ARSIZE_i  (arsize),
    .m_ARBURST_i (arburst),
    .m_ARVALID_i (arvalid),
    .m_ARREADY_o (arready),
    .m_RID_o     (rid),
    .m_RDATA_o   (rdata),
    .m_RRESP_o   (rresp),
    .m_RLAST_o   (rlast),
    .m_RVALID_o  (rvalid),
    .m_RREADY_i  (rready),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
    logic [RW-1:0]   resp;
    logic            last;
  } beat_t;

  beat_t         exp_beats[$];
  logic [AW-1:0] exp_maddr[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C5A_0000;
  endfunction

  // Synchronous memory: data for a strobed address appears the following cycle
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= data_of(mem_addr);
  end

  function automatic bit is_err(input int len, input int size, input logic [1:0] burst);
    return (burst == 2'b11) || (size > 2) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] addr, input int len,
                                              input int size, input logic [1:0] burst,
                                              input bit err, input int i);
    logic [AW-1:0] s;
    logic [AW-1:0] l;
    logic [AW-1:0] base;
    s = 32'(1) << size;
    if (i == 0) return addr;
    if (err || burst == 2'b01) return (addr & ~(s - 32'd1)) + 32'(i) * s;
    if (burst == 2'b00) return addr;
    l    = 32'(len + 1) * s;
    base = addr - (addr % l);
    return base + ((addr - base + 32'(i) * s) % l);
  endfunction

  task automatic expect_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                              input int len, input int size, input logic [1:0] burst);
    bit            err;
    logic [AW-1:0] a;
    beat_t         b;
    err = is_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, err, i) & ~32'd3;
      exp_maddr.push_back(a);
      b.id   = id;
      b.data = data_of(a);
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      exp_beats.push_back(b);
    end
  endtask

  // Monitor: memory strobes, accepted beats and hold-stability under backpressure
  beat_t cur_beat;
  beat_t hold_beat;
  bit    hold_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (exp_maddr.size() == 0) check_eq("maddr_unexpected", 1, 0);
        else check_eq("mem_addr", mem_addr, exp_maddr.pop_front());
      end
      cur_beat = '{rid, rdata, rresp, rlast};
      if (hold_vld) check_eq("r_stable", cur_beat, hold_beat);
      if (rvalid && rready) begin
        if (exp_beats.size() == 0) check_eq("beat_unexpected", 1, 0);
        else check_eq("r_beat", cur_beat, exp_beats.pop_front());
        $display("[TB] beat id=%0h data=%08h resp=%0d last=%0d", rid, rdata, rresp, rlast);
      end
      hold_vld  = rvalid && !rready;
      hold_beat = cur_beat;
    end
  end

  // Called at posedge+2; leaves at posedge+2 of the cycle after the handshake
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                         input int len, input int size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (arready) expect_burst(id, addr, len, size, burst);
    else check_eq("ar_timeout", 0, 1);
    $display("[TB] AR id=%0h addr=%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    @(posedge clk); #2;
    arvalid = 1'b0;
  endtask

  task automatic try_ar(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                        input int len, output bit accepted);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    @(negedge clk);
    accepted = arready;
    if (accepted) expect_burst(id, addr, len, 2, 2'b01);
    @(posedge clk); #2;
    arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_beats.size() != 0 || rvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < 500), 1);
    repeat (3) @(negedge clk);
    check_eq("maddr_left", exp_maddr.size(), 0);
    @(posedge clk); #2;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_rvalid", rvalid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_arready", arready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_mem_rd_en", mem_rd_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("arready_after_rst", arready, 1);

    // INCR burst with latency and back-to-back beat timing
    send_ar(7'h05, 32'h100, 3, 2, 2'b01);
    @(negedge clk); check_eq("lat_c1_rvalid", rvalid, 0);
    @(negedge clk); check_eq("lat_c2_rd_en", mem_rd_en, 1);
    @(negedge clk); check_eq("lat_c3_rvalid", rvalid, 0);
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk);
      check_eq("burst_rvalid", rvalid, 1);
      check_eq("burst_rlast", rlast, (c == 7));
    end
    drain("drain_incr");

    send_ar(7'h12, 32'h1C, 3, 2, 2'b10);
    drain("drain_wrap");
    send_ar(7'h21, 32'h80, 2, 2, 2'b00);
    drain("drain_fixed");
    send_ar(7'h2A, 32'h700, 1, 1, 2'b01);
    send_ar(7'h2B, 32'h38, 7, 2, 2'b10);
    drain("drain_pair");

    // Illegal bursts: reserved type, bad WRAP length, oversize beat
    send_ar(7'h33, 32'h300, 1, 2, 2'b11);
    send_ar(7'h34, 32'h40, 2, 2, 2'b10);
    send_ar(7'h35, 32'h50, 0, 3, 2'b01);
    drain("drain_err");

    // Backpressure mid-burst
    send_ar(7'h44, 32'h200, 7, 2, 2'b01);
    wait_rvalid();
    @(posedge clk); #2;
    rready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 3) check_eq("stall_no_rd_en", mem_rd_en, 0);
    end
    @(posedge clk); #2;
    rready = 1'b1;
    drain("drain_stall");

    // Queue fill: 8 queued plus the one held by the burst walker
    rready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      try_ar(7'(8'h50 + i), 32'h400 + 32'(i) * 32'h40, 3, acc);
      check_eq("ar_accept", acc, 1);
    end
    for (int k = 0; k < 5; k++) begin
      try_ar(7'h60, 32'hA00, 3, acc);
      check_eq("ar_full_block", acc, 0);
    end
    rready = 1'b1;
    send_ar(7'h60, 32'hA00, 3, 2, 2'b01);
    drain("drain_full");

    // Reset mid-burst
    send_ar(7'h70, 32'h500, 15, 2, 2'b01);
    wait_rvalid();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_rvalid", rvalid, 0);
    check_eq("rst_mid_rd_en", mem_rd_en, 0);
    check_eq("rst_mid_arready", arready, 0);
    exp_beats.delete();
    exp_maddr.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("rst_mid_arready_rel", arready, 1);
    send_ar(7'h71, 32'h600, 1, 2, 2'b01);
    drain("drain_after_rst");

    check_eq("queues_empty", exp_beats.size() + exp_maddr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
